sseg_scan_ctrl: RTL
===================

Name: sseg_scan_ctrl

Overview:
Time-multiplexing scan controller that sits directly upstream of the seven-segment digit driver. It holds an 8-digit right-justified character buffer fed by the Morse decoder, one 4-bit code per accepted character. It cycles through the digits at a fixed refresh rate and, on each cycle, presents one digit's code, index, decimal-point control and enable to the driver.

Parameters:
DIGITS, 8, number of display digits; active_digit width is fixed at 3, so DIGITS must be 2..8
REFRESH_DIV, 100000, clock cycles each digit stays active (1 kHz per digit at 100 MHz)
CW, 17, prescaler counter width; must satisfy 2^CW >= REFRESH_DIV

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
char_valid  input  1  one-cycle strobe: char_code is a new decoded character
char_code  input  4  code of the new character
backspace  input  1  one-cycle strobe: remove the most recent character
clear  input  1  one-cycle strobe: empty the buffer
disp_en  input  1  global display enable
dp_mask  input  DIGITS  decimal point request per digit, bit i = digit i, 1 = lit
num  output  4  code for the active digit, to the driver's num input
active_digit  output  3  index of the active digit, 0 = rightmost
DP_ctrl  output  1  decimal point for the active digit, active-low (0 = lit)
en  output  1  decoder enable; 0 blanks the active digit (all anodes off)
fill  output  4  number of valid characters in the buffer, 0..DIGITS

Behaviour:
- Reset (reset_n=0, asynchronous): buffer cleared to 0, fill=0, prescaler=0, scan index=0, num=0, active_digit=0, DP_ctrl=1, en=0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps to 0. A tick is asserted in the cycle where the count equals REFRESH_DIV-1.
- Scan index: advances by 1 on each tick and wraps from DIGITS-1 to 0.
- Scanning runs whenever reset is deasserted, independent of disp_en and of buffer activity.
- Buffer storage: entries buf[0..DIGITS-1] plus the fill counter. Valid entries always occupy indices 0..fill-1.
- char_valid: char_code is written into buf[0] and buf[i] moves to buf[i+1].
  - fill increments and saturates at DIGITS.
  - When the buffer is full, the old buf[DIGITS-1] is discarded.
- backspace: buf[i+1] moves to buf[i], the top entry becomes 0, and fill decrements.
  - When fill=0, backspace has no effect.
- clear: all entries become 0 and fill=0.
- Buffer updates take effect in the cycle after the strobe.
- Simultaneous strobes: clear has highest priority, then char_valid, then backspace. Lower-priority strobes in the same cycle are ignored.
- Outputs are registered every cycle from the current scan index and buffer state, so latency from an index or buffer change to the outputs is 1 cycle.
  - active_digit <= scan index.
  - num <= buf[scan index].
  - en <= disp_en AND (scan index < fill). Unfilled digits are blanked.
  - DP_ctrl <= NOT(dp_mask[scan index] AND disp_en). dp_mask is honoured on blank digits too.
- Reset asserted mid-scan or mid-update: everything returns to the reset values immediately. After release, scanning restarts at digit 0 with a full REFRESH_DIV period.
- No handshake back-pressure: every strobe is accepted in its own cycle. The upstream logic must present strobes as single-cycle pulses.

Decomposition:
- Shared package sseg_pkg holds:
  - DIGIT_IDX_W = 3
  - CODE_W = 4
  - default DIGITS and REFRESH_DIV
  - character-code constants shared with the Morse decoder, e.g. CODE_BLANK = 4'h0
- One sub-module, refresh_prescaler (parameters REFRESH_DIV and CW; outputs tick), is natural and can be reused by the Morse timing logic.

Test Plan:
1. REFRESH_DIV=4, reset, no characters, disp_en=1 -> active_digit steps 0,1,...,7,0 every 4 cycles; en=0 throughout; DP_ctrl=1.
2. char_valid with codes 3 then 5 -> fill=2, buf[0]=5, buf[1]=3. Scanning shows en=1 with num=5 at digit 0 and num=3 at digit 1; digits 2..7 have en=0.
3. Nine char_valid strobes, codes 1..9 -> fill=8; digit 0 shows 9 and digit 7 shows 2; code 1 is dropped.
4. backspace with fill=2 (5,3) -> fill=1, digit 0 shows 3. A second backspace gives fill=0. A third backspace leaves fill=0 with no change.
5. clear, char_valid and backspace asserted in the same cycle with fill=3 -> fill=0 on the next cycle and all digits blank.
6. dp_mask=8'h04 with disp_en toggling -> DP_ctrl=0 only while active_digit=2 and disp_en=1. When disp_en=0, en=0 and DP_ctrl=1 on every digit, and scanning continues.
7. Assert reset_n=0 mid-period -> outputs return to reset values in the same cycle. After release, the first tick occurs REFRESH_DIV cycles later.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared widths, defaults and character codes for the seven-segment display path.
// The Morse decoder uses the same character codes.
package sseg_pkg;

    localparam int DIGIT_IDX_W         = 3;
    localparam int CODE_W              = 4;
    localparam int FILL_W              = 4;
    localparam int DEFAULT_DIGITS      = 8;
    localparam int DEFAULT_REFRESH_DIV = 100000;

    localparam logic [CODE_W-1:0] CODE_BLANK = 4'h0;

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Character-buffer strobes in, per-digit driver controls out.
// The master side is the Morse decoder; the slave side is the scan controller.
interface sseg_scan_if
    import sseg_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS
);

    logic                   char_valid;
    logic [CODE_W-1:0]      char_code;
    logic                   backspace;
    logic                   clear;
    logic                   disp_en;
    logic [DIGITS-1:0]      dp_mask;
    logic [CODE_W-1:0]      num;
    logic [DIGIT_IDX_W-1:0] active_digit;
    logic                   DP_ctrl;
    logic                   en;
    logic [FILL_W-1:0]      fill;

    modport master (
        output char_valid, char_code, backspace, clear, disp_en, dp_mask,
        input  num, active_digit, DP_ctrl, en, fill
    );

    modport slave (
        input  char_valid, char_code, backspace, clear, disp_en, dp_mask,
        output num, active_digit, DP_ctrl, en, fill
    );

endinterface

// File: rtl/sseg_scan_ctrl_prescaler.sv
// Free-running divider that emits a one-cycle tick every REFRESH_DIV clocks.
// The Morse timing logic reuses this block as well.
module refresh_prescaler #(
    parameter int REFRESH_DIV = 100000,
    parameter int CW          = 17
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    logic [CW-1:0] count;

    assign tick = (count == CW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Scan controller: right-justified character buffer plus time-multiplexed digit
// selection, with registered per-digit outputs for the seven-segment driver.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int DIGITS      = DEFAULT_DIGITS,
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
    parameter int CW          = 17
) (
    input  logic        clk,
    input  logic        reset_n,
    sseg_scan_if.slave  bus
);

    logic                   tick;
    logic [DIGIT_IDX_W-1:0] scan_idx;
    logic [CODE_W-1:0]      char_buf [DIGITS];
    logic [FILL_W-1:0]      fill_q;

    refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .CW          (CW)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_idx <= '0;
        end else if (tick) begin
            if (scan_idx == DIGIT_IDX_W'(DIGITS - 1)) begin
                scan_idx <= '0;
            end else begin
                scan_idx <= scan_idx + 1'b1;
            end
        end
    end

    // Strobe priority is clear > char_valid > backspace; index 0 is the newest character.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                char_buf[i] <= CODE_BLANK;
            end
            fill_q <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i < DIGITS; i++) begin
                char_buf[i] <= CODE_BLANK;
            end
            fill_q <= '0;
        end else if (bus.char_valid) begin
            char_buf[0] <= bus.char_code;
            for (int i = 1; i < DIGITS; i++) begin
                char_buf[i] <= char_buf[i-1];
            end
            if (fill_q != FILL_W'(DIGITS)) begin
                fill_q <= fill_q + 1'b1;
            end
        end else if (bus.backspace && (fill_q != '0)) begin
            for (int i = 0; i < DIGITS - 1; i++) begin
                char_buf[i] <= char_buf[i+1];
            end
            char_buf[DIGITS-1] <= CODE_BLANK;
            fill_q <= fill_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.num          <= CODE_BLANK;
            bus.active_digit <= '0;
            bus.DP_ctrl      <= 1'b1;
            bus.en           <= 1'b0;
        end else begin
            bus.num          <= char_buf[scan_idx];
            bus.active_digit <= scan_idx;
            bus.DP_ctrl      <= ~(bus.dp_mask[scan_idx] & bus.disp_en);
            bus.en           <= bus.disp_en & ({1'b0, scan_idx} < fill_q);
        end
    end

    assign bus.fill = fill_q;

endmodule
